alu_share_arbiter: RTL



---
 rtl/alu_share_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional grant/overflow statistics counters are enabled with `define ALU_ARB_STATS_EN.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [OP_W-1:0]   alu_ctrl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_overflow,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_overflow,
    output logic              rsp_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1,
    output logic [15:0]       ovf_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'b0010);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'b0110);
    localparam logic [OP_W-1:0] OP_SLT = OP_W'(4'b0111);

    state_t state;
    logic   rr_ptr;
    logic   grant_valid;
    logic   grant_id;
    logic   accept;
    logic   ovf_op;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = rr_ptr;
        end else begin
            grant_id = req1_valid;
        end
    end

    assign accept     = (state == IDLE) && grant_valid;
    // Ready is a same-cycle grant; rst_n gating keeps it low while reset is held.
    assign req0_ready = rst_n && accept && !grant_id;
    assign req1_ready = rst_n && accept && grant_id;

    // Only arithmetic ops report overflow; logic ops and unknown codes mask it.
    assign ovf_op = (alu_ctrl == OP_ADD) || (alu_ctrl == OP_SUB) || (alu_ctrl == OP_SLT);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= 1'b0;
            alu_ctrl     <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        alu_ctrl <= grant_id ? req1_op : req0_op;
                        alu_a    <= grant_id ? req1_a  : req0_a;
                        alu_b    <= grant_id ? req1_b  : req0_b;
                        rsp_id   <= grant_id;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result   <= alu_result;
                    rsp_zero     <= alu_zero;
                    rsp_overflow <= alu_overflow & ovf_op;
                    rsp_valid    <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= ~rsp_id;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            ovf_cnt    <= '0;
        end else begin
            if (accept && !grant_id && grant_cnt0 != 16'hFFFF) begin
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end
            if (accept && grant_id && grant_cnt1 != 16'hFFFF) begin
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end
            if (state == EXEC && alu_overflow && ovf_op && ovf_cnt != 16'hFFFF) begin
                ovf_cnt <= ovf_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
